// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the CDB arbiter: FU categories, default FU counts
// and helpers mapping a category to its contiguous FU index range.
package sys_defs;

    typedef enum logic [1:0] {
        CAT_ALU  = 2'd0,
        CAT_LS   = 2'd1,
        CAT_MULT = 2'd2,
        CAT_BEQ  = 2'd3
    } cat_e;

    localparam int DEF_NUM_ALU   = 8;
    localparam int DEF_NUM_LS    = 4;
    localparam int DEF_NUM_MULT  = 4;
    localparam int DEF_NUM_BEQ   = 4;
    localparam int DEF_NUM_CDB   = 2;
    localparam int DEF_AGE_LIMIT = 7;

    // First FU index of a category (FUs laid out ALU, LS, MULT, BEQ)
    function automatic int cat_base(input int c, input int n_alu, input int n_ls, input int n_mult);
        case (c)
            0:       return 0;
            1:       return n_alu;
            2:       return n_alu + n_ls;
            default: return n_alu + n_ls + n_mult;
        endcase
    endfunction

    function automatic int cat_size(input int c, input int n_alu, input int n_ls,
                                    input int n_mult, input int n_beq);
        case (c)
            0:       return n_alu;
            1:       return n_ls;
            2:       return n_mult;
            default: return n_beq;
        endcase
    endfunction

    function automatic cat_e cat_of(input int idx, input int n_alu, input int n_ls, input int n_mult);
        if (idx < n_alu)                 return CAT_ALU;
        if (idx < n_alu + n_ls)          return CAT_LS;
        if (idx < n_alu + n_ls + n_mult) return CAT_MULT;
        return CAT_BEQ;
    endfunction

    // One-hot {BEQ,MULT,LS,ALU}
    function automatic logic [3:0] cat_onehot(input cat_e c);
        return 4'b0001 << c;
    endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// Request/grant bundle between the functional units and the CDB arbiter.
interface cdb_arbiter_if #(
    parameter int FU_SIZE = 20,
    parameter int NUM_CDB = 2,
    parameter int IDX_W   = 5
);
    logic                              squash;
    logic [FU_SIZE-1:0]                fu_result_valid;
    logic [FU_SIZE-1:0]                fu_ack;
    logic [NUM_CDB-1:0]                cdb_valid;
    logic [NUM_CDB-1:0][IDX_W-1:0]     cdb_fu_num;
    logic [NUM_CDB-1:0][3:0]           cdb_cat;

    modport master (output squash, fu_result_valid,
                    input  fu_ack, cdb_valid, cdb_fu_num, cdb_cat);
    modport slave  (input  squash, fu_result_valid,
                    output fu_ack, cdb_valid, cdb_fu_num, cdb_cat);
endinterface

// File: rtl/cdb_arbiter_rr_picker.sv
// Round-robin one-hot picker: lowest set request at or after ptr, wrapping.
module rr_picker #(
    parameter int W  = 4,
    parameter int PW = 2
) (
    input  logic [W-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [W-1:0]  gnt
);
    logic [2*W-1:0] dbl;
    logic [2*W-1:0] rot_back;
    logic [W-1:0]   rot;
    logic [W-1:0]   low;

    // Rotate so ptr sits at bit 0, isolate lowest set bit, rotate back
    always_comb begin
        dbl      = {req, req} >> ptr;
        rot      = dbl[W-1:0];
        low      = rot & (~rot + W'(1));
        rot_back = {low, low} << ptr;
        gnt      = rot_back[2*W-1:W];
    end
endmodule

// File: rtl/cdb_arbiter.sv
// CDB arbiter: fills NUM_CDB broadcast slots per cycle, starved FUs first,
// then BEQ > MULT > LS > ALU with round-robin inside each category.
module cdb_arbiter import sys_defs::*; #(
    parameter int NUM_ALU   = DEF_NUM_ALU,
    parameter int NUM_LS    = DEF_NUM_LS,
    parameter int NUM_MULT  = DEF_NUM_MULT,
    parameter int NUM_BEQ   = DEF_NUM_BEQ,
    parameter int NUM_CDB   = DEF_NUM_CDB,
    parameter int AGE_LIMIT = DEF_AGE_LIMIT
) (
    input logic         clock,
    input logic         reset,
    cdb_arbiter_if.slave bus
);
    localparam int FU_SIZE = NUM_ALU + NUM_LS + NUM_MULT + NUM_BEQ;
    localparam int IDX_W   = $clog2(FU_SIZE);
    localparam int AGE_W   = $clog2(AGE_LIMIT + 1);

    logic [AGE_W-1:0]   age_q [FU_SIZE];
    logic [AGE_W-1:0]   age_d [FU_SIZE];
    logic [IDX_W-1:0]   ptr_q [4];
    logic [IDX_W-1:0]   ptr_d [4];
    int                 hi [4];
    logic [FU_SIZE-1:0] req_v;
    logic [FU_SIZE-1:0] starved;
    logic [FU_SIZE-1:0] slot_pick [NUM_CDB];
    logic [FU_SIZE-1:0] ack;
    logic [NUM_CDB-1:0]            cdb_valid;
    logic [NUM_CDB-1:0][IDX_W-1:0] cdb_fu_num;
    logic [NUM_CDB-1:0][3:0]       cdb_cat;

    // Squash and reset both blank every grant in the current cycle
    assign req_v = (bus.squash || reset) ? '0 : bus.fu_result_valid;

    // An FU is starved once its wait count reaches the limit
    always_comb begin
        for (int i = 0; i < FU_SIZE; i++)
            starved[i] = (age_q[i] == AGE_W'(AGE_LIMIT));
    end

    for (genvar k = 0; k < NUM_CDB; k++) begin : g_slot
        logic [FU_SIZE-1:0] avail;
        logic [FU_SIZE-1:0] pick;
        logic [FU_SIZE-1:0] stv;
        logic [FU_SIZE-1:0] cat_pick [4];

        // Each slot only sees FUs not already taken by earlier slots
        if (k == 0) begin : g_head
            assign avail = req_v;
        end else begin : g_chain
            assign avail = g_slot[k-1].avail & ~g_slot[k-1].pick;
        end

        for (genvar c = 0; c < 4; c++) begin : g_cat
            localparam int B = cat_base(c, NUM_ALU, NUM_LS, NUM_MULT);
            localparam int S = cat_size(c, NUM_ALU, NUM_LS, NUM_MULT, NUM_BEQ);
            if (S > 0) begin : g_pick
                logic [S-1:0] gnt;
                rr_picker #(.W(S), .PW(IDX_W)) u_rr (
                    .req (avail[B +: S]),
                    .ptr (ptr_q[c]),
                    .gnt (gnt)
                );
                assign cat_pick[c] = FU_SIZE'(gnt) << B;
            end else begin : g_none
                assign cat_pick[c] = '0;
            end
        end

        assign stv = avail & starved;

        // Lowest-index starved FU wins, else first category with a request
        always_comb begin
            if (|stv)                      pick = stv & (~stv + FU_SIZE'(1));
            else if (|cat_pick[CAT_BEQ])   pick = cat_pick[CAT_BEQ];
            else if (|cat_pick[CAT_MULT])  pick = cat_pick[CAT_MULT];
            else if (|cat_pick[CAT_LS])    pick = cat_pick[CAT_LS];
            else                           pick = cat_pick[CAT_ALU];
        end

        assign slot_pick[k] = pick;
    end

    // Encode slot picks onto the bus; empty slots read as all zero
    always_comb begin
        ack        = '0;
        cdb_valid  = '0;
        cdb_fu_num = '0;
        cdb_cat    = '0;
        for (int k = 0; k < NUM_CDB; k++) begin
            ack          = ack | slot_pick[k];
            cdb_valid[k] = |slot_pick[k];
            for (int i = 0; i < FU_SIZE; i++) begin
                if (slot_pick[k][i]) begin
                    cdb_fu_num[k] = IDX_W'(i);
                    cdb_cat[k]    = cat_onehot(cat_of(i, NUM_ALU, NUM_LS, NUM_MULT));
                end
            end
        end
    end

    assign bus.fu_ack     = ack;
    assign bus.cdb_valid  = cdb_valid;
    assign bus.cdb_fu_num = cdb_fu_num;
    assign bus.cdb_cat    = cdb_cat;

    // Next ages (count only while waiting) and per-category pointer advance
    always_comb begin
        for (int i = 0; i < FU_SIZE; i++) begin
            if (bus.squash || !bus.fu_result_valid[i] || ack[i]) age_d[i] = '0;
            else if (starved[i])                                 age_d[i] = age_q[i];
            else                                                 age_d[i] = age_q[i] + AGE_W'(1);
        end
        for (int c = 0; c < 4; c++) hi[c] = -1;
        // Ascending scan leaves the highest granted offset per category
        for (int i = 0; i < FU_SIZE; i++) begin
            if (ack[i])
                hi[int'(cat_of(i, NUM_ALU, NUM_LS, NUM_MULT))] =
                    i - cat_base(int'(cat_of(i, NUM_ALU, NUM_LS, NUM_MULT)), NUM_ALU, NUM_LS, NUM_MULT);
        end
        for (int c = 0; c < 4; c++) begin
            ptr_d[c] = ptr_q[c];
            if (hi[c] >= 0)
                ptr_d[c] = (hi[c] + 1 >= cat_size(c, NUM_ALU, NUM_LS, NUM_MULT, NUM_BEQ))
                           ? '0 : IDX_W'(hi[c] + 1);
        end
    end

    // State registers; reset drops all starvation history and pointers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FU_SIZE; i++) age_q[i] <= '0;
            for (int c = 0; c < 4; c++)       ptr_q[c] <= '0;
        end else begin
            for (int i = 0; i < FU_SIZE; i++) age_q[i] <= age_d[i];
            for (int c = 0; c < 4; c++)       ptr_q[c] <= ptr_d[c];
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic checked
// against a slot-filling reference model; extra configurations checked
// for grant-count and slot-shape invariants.
module tb_cdb_arbiter;
    localparam int FS = 20;
    localparam int NC = 2;
    localparam int IW = 5;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        squash = 1'b0;
    logic [19:0] valid  = '0;
    int          n_vec  = 0;
    int          n_err  = 0;

    always #5 clk = ~clk;

    cdb_arbiter_if #(.FU_SIZE(FS), .NUM_CDB(NC), .IDX_W(IW)) bus();
    assign bus.squash          = squash;
    assign bus.fu_result_valid = valid;

    cdb_arbiter u_dut (.clock(clk), .reset(rst), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Other configurations: invariant checks only
    localparam int SW_CDB [3] = '{1, 3, 4};
    localparam int SW_LS  [3] = '{4, 1, 4};
    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int SNC = SW_CDB[g];
        localparam int SFS = 16 + SW_LS[g];
        cdb_arbiter_if #(.FU_SIZE(SFS), .NUM_CDB(SNC), .IDX_W($clog2(SFS))) sb();
        assign sb.squash          = squash;
        assign sb.fu_result_valid = valid[SFS-1:0];
        cdb_arbiter #(.NUM_LS(SW_LS[g]), .NUM_CDB(SNC)) u_sw (.clock(clk), .reset(rst), .bus(sb));
        always @(negedge clk) begin
            int n;
            n = $countones(valid[SFS-1:0]);
            if (n > SNC) n = SNC;
            if (rst || squash) n = 0;
            chk($sformatf("sw%0d_popcount", g), 32'($countones(sb.fu_ack)), n);
            chk($sformatf("sw%0d_thermo", g), 32'(sb.cdb_valid), (32'd1 << n) - 1);
            chk($sformatf("sw%0d_subset", g), 32'(sb.fu_ack & ~valid[SFS-1:0]), 0);
        end
    end

    // Reference model for the default configuration
    int          m_age [20];
    int          m_ptr [4];
    logic [19:0] e_ack;
    int          e_n;
    int          e_fu  [2];
    int          e_cat [2];

    function automatic int cbase(input int c);
        return (c == 0) ? 0 : (c == 1) ? 8 : (c == 2) ? 12 : 16;
    endfunction
    function automatic int csize(input int c);
        return (c == 0) ? 8 : 4;
    endfunction
    function automatic int catof(input int f);
        return (f < 8) ? 0 : (f < 12) ? 1 : (f < 16) ? 2 : 3;
    endfunction

    task automatic model_reset();
        for (int f = 0; f < 20; f++) m_age[f] = 0;
        for (int c = 0; c < 4; c++)  m_ptr[c] = 0;
    endtask

    task automatic model_eval(input logic [19:0] v, input logic sq);
        int pick, i;
        e_ack = '0; e_n = 0; e_fu = '{0, 0}; e_cat = '{0, 0};
        if (!sq) begin
            for (int s = 0; s < 2; s++) begin
                pick = -1;
                for (int f = 0; f < 20; f++)
                    if (pick < 0 && v[f] && !e_ack[f] && m_age[f] == 7) pick = f;
                for (int c = 3; c >= 0; c--)
                    for (int j = 0; j < csize(c); j++) begin
                        i = cbase(c) + (m_ptr[c] + j) % csize(c);
                        if (pick < 0 && v[i] && !e_ack[i]) pick = i;
                    end
                if (pick >= 0) begin
                    e_ack[pick] = 1'b1; e_fu[s] = pick; e_cat[s] = 1 << catof(pick); e_n++;
                end
            end
        end
    endtask

    task automatic model_commit(input logic [19:0] v, input logic sq);
        int hi;
        for (int f = 0; f < 20; f++) begin
            if (sq || !v[f] || e_ack[f]) m_age[f] = 0;
            else if (m_age[f] < 7)       m_age[f] = m_age[f] + 1;
        end
        for (int c = 0; c < 4; c++) begin
            hi = -1;
            for (int j = 0; j < csize(c); j++) if (e_ack[cbase(c) + j]) hi = j;
            if (hi >= 0) m_ptr[c] = (hi + 1) % csize(c);
        end
    endtask

    // One clock: drive, compare at negedge, model follows the clock edge
    task automatic step(input logic [19:0] v, input logic sq, input logic dchk, input logic [19:0] dack);
        valid = v; squash = sq;
        @(negedge clk);
        model_eval(v, sq);
        chk("ack", 32'(bus.fu_ack), 32'(e_ack));
        chk("cdb_valid", 32'(bus.cdb_valid), (e_n == 0) ? 0 : (e_n == 1) ? 1 : 3);
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("fu_num%0d", s), 32'(bus.cdb_fu_num[s]), e_fu[s]);
            chk($sformatf("cat%0d", s), 32'(bus.cdb_cat[s]), e_cat[s]);
        end
        if (dchk) chk("directed_ack", 32'(bus.fu_ack), 32'(dack));
        @(posedge clk); #1;
        model_commit(v, sq);
    endtask

    task automatic do_reset(input logic [19:0] v);
        rst = 1'b1; valid = v; squash = 1'b0;
        @(negedge clk);
        chk("rst_ack", 32'(bus.fu_ack), 0);
        chk("rst_cdb_valid", 32'(bus.cdb_valid), 0);
        chk("rst_fu_num", 32'(bus.cdb_fu_num), 0);
        @(posedge clk); #1;
        rst = 1'b0; valid = '0;
        model_reset();
    endtask

    logic [19:0] rv;
    logic        rsq;
    logic [19:0] pairs [5];

    initial begin
        model_reset();
        do_reset(20'hFFFFF);

        // Mixed ALU/LS: LS first, then ALU0; ALU pointer moves to 1
        step(20'h00109, 1'b0, 1'b1, 20'h00101);
        step(20'h00109, 1'b0, 1'b1, 20'h00108);

        // ALU-only round robin in pairs
        do_reset('0);
        pairs = '{20'h3, 20'hC, 20'h30, 20'hC0, 20'h3};
        for (int k = 0; k < 5; k++) step(20'h000FF, 1'b0, 1'b1, pairs[k]);

        // BEQ hogs both slots until ALU5 and MULT12 starve on cycle 8
        do_reset('0);
        for (int k = 1; k <= 8; k++)
            step(20'h31020, 1'b0, 1'b1, (k < 8) ? 20'h30000 : 20'h01020);

        // Squash wipes accumulated age
        do_reset('0);
        for (int k = 0; k < 7; k++) step(20'h30020, 1'b0, 1'b1, 20'h30000);
        step(20'h30020, 1'b1, 1'b1, 20'h00000);
        step(20'h30020, 1'b0, 1'b1, 20'h30000);

        // Asynchronous reset in mid cycle with five requesters
        do_reset('0);
        step(20'h11109, 1'b0, 1'b0, '0);
        step(20'h11109, 1'b0, 1'b0, '0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ack", 32'(bus.fu_ack), 0);
        chk("async_rst_cdb_valid", 32'(bus.cdb_valid), 0);
        chk("async_rst_fu_num", 32'(bus.cdb_fu_num), 0);
        chk("async_rst_cat", 32'(bus.cdb_cat), 0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        step(20'h11109, 1'b0, 1'b1, 20'h11000);

        // Random traffic
        for (int t = 0; t < 400; t++) begin
            rv = 20'($urandom) & 20'($urandom);
            if (t % 3 == 0)  rv = 20'($urandom);
            if (t % 50 == 7) rv = 20'hFFFFF;
            rsq = ($urandom_range(0, 15) == 0);
            if (t % 100 == 99) do_reset(20'($urandom));
            else               step(rv, rsq, 1'b0, '0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
